conv_encoder: RTL
=================

# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder (generators G0 = 111, G1 = 101; 4 trellis states) that feeds the Viterbi decoder. It accepts an N-bit message word on a start pulse and encodes it serially, one bit per cycle. It streams each 2-bit symbol as it is produced and assembles the full 2N-bit code word. The code word is packed so it connects directly to the decoder's `code_in` bus, with symbol 0 at the LSBs.

## Interface
- `N`, default 10: message length in bits; code word is 2N bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `st`, input, 1: start pulse; sampled only in IDLE.
- `data_in`, input, N: message word; `data_in[0]` is encoded first.
- `sym_out`, output, 2: current symbol `{g0, g1}`; valid while `sym_valid` = 1.
- `sym_valid`, output, 1: high for each of the N encode cycles.
- `code_out`, output, 2N: assembled code word; `code_out[2i+1:2i]` is the symbol for `data_in[i]`.
- `busy`, output, 1: high from the cycle after `st` is accepted until `done`, inclusive.
- `done`, output, 1: one-cycle pulse when `code_out` is complete.

## Operation
- **Reset values.** All outputs are 0. FSM is in IDLE, counter = 0, trellis state `{s1, s0}` = 00.
- **FSM states.** IDLE, ENC, DONE.
- **IDLE, `st` = 1:**
  - latch `data_in` into the message register;
  - clear `{s1, s0}` to 00 and the counter to 0;
  - clear `code_out`;
  - go to ENC.
- **ENC, one cycle per bit.** Take `u = msg[cnt]` and compute:
  - `g0 = u ^ s1 ^ s0` and `g1 = u ^ s0`;
  - `sym_out = {g0, g1}` and `sym_valid = 1`;
  - write the symbol into `code_out[2cnt+1:2cnt]`;
  - update state: `s0 <= s1`, `s1 <= u`, `cnt <= cnt + 1`.
- **ENC to DONE.** Transition when `cnt = N-1` has been processed.
- **DONE.** `done = 1` for one cycle, then return to IDLE.
- **Counter width.** Counter is clog2(N) bits. It never wraps, because the exit is at N-1.
- **Output hold.** `code_out` holds its value until the next accepted `st`. `sym_out` returns to 00 whenever `sym_valid` = 0.
- **`st` outside IDLE.** Ignored in ENC and DONE. `data_in` changes after acceptance have no effect.
- **Reset mid-operation.** Asserting `rst` during ENC or DONE aborts immediately. All outputs and state take their reset values, and no `done` is issued.
- **Single-cycle start.** `st` held high for multiple cycles starts exactly one encode. It is re-accepted only once back in IDLE, so a `st` still high in the IDLE cycle after DONE starts a new encode.

## Timing
- `st` is sampled high at edge k (in IDLE). Symbols are then output on cycles k+1 … k+N.
- `done` and the final `code_out` are valid in cycle k+N+1.
- Throughput: one message per N+2 cycles when `st` is held high.
- `busy` is high in cycles k+1 … k+N+1.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- **`CONV_ENC_TAIL_EN` defined:** zero-termination. Message bits `N-2` and `N-1` are forced to 0 regardless of `data_in`, so the trellis ends in state 00 for the decoder's traceback.
- **`CONV_ENC_TAIL_EN` undefined:** all N bits of `data_in` are encoded as given, and the final state is arbitrary.

## Test plan
- **Reset.** Assert `rst` = 0 at any time, then release → all outputs are 0 and the block is in IDLE. A `st` issued afterwards works normally.
- **Mixed message.** `data_in` = 10'b0000001011, `st` pulse, macro undefined:
  - `sym_out` sequence is 11, 01, 01, 00, 10, 11, 00, 00, 00, 00;
  - `code_out` = 20'h00E17 with `done` 11 cycles after `st`.
- **All ones.** `data_in` = 10'h3FF, macro undefined → `code_out` = 20'hAAAA7.
- **All ones with tail.** Same stimulus with `CONV_ENC_TAIL_EN` defined → `code_out` = 20'hDAAA7.
- **Mid-run start.** `st` re-pulsed during ENC with a different `data_in` → ignored. `code_out` still reflects the first message and exactly one `done` is produced.
- **Mid-run reset and loopback.**
  - `rst` asserted at the 5th ENC cycle → no `done`, `code_out` = 0. A new `st` then encodes correctly from state 00.
  - Loopback: `code_out` from the 20'h00E17 case, fed to the decoder `code_in` → decoder `data_out` = 10'b0000001011.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (G0 = 111, G1 = 101) feeding the
// Viterbi decoder. Encodes an N-bit word serially, one bit per cycle, and
// streams each {g0, g1} symbol. It also packs the full 2N-bit code word,
// with symbol i at code_out[2i+1:2i].
//
// Optional feature macro: CONV_ENC_TAIL_EN
//   defined   -> message bits N-2 and N-1 are forced to 0 (zero-terminated
//                trellis, final state 00)
//   undefined -> all N bits of data_in are encoded as given
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for st; outputs idle, code_out holds last code word
// ENC   | one message bit per cycle, sym_out/sym_valid live
// DONE  | code_out complete, done pulses for this one cycle
module conv_encoder #(
  parameter int N = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [N-1:0]   data_in,
  output logic [1:0]     sym_out,
  output logic           sym_valid,
  output logic [2*N-1:0] code_out,
  output logic           busy,
  output logic           done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef CONV_ENC_TAIL_EN
  localparam logic [N-1:0] MSG_MASK = {2'b00, {(N - 2){1'b1}}};
`else
  localparam logic [N-1:0] MSG_MASK = '1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  msg;
  logic [CW-1:0] cnt;
  logic          s1;
  logic          s0;

  logic [N-1:0]  msg_load;
  logic [CW-1:0] cnt_nxt;
  logic          u_nxt;
  logic [1:0]    sym_nxt;

  // Symbols are precomputed one cycle ahead so sym_out can be a register
  // and still be valid in the first cycle after st is accepted. As a
  // result, {s1, s0} already includes the bit whose symbol sits in sym_out.
  always_comb begin
    msg_load = data_in & MSG_MASK;
    cnt_nxt  = cnt + 1'b1;
    u_nxt    = 1'b0;
    if (cnt != LAST) begin
      u_nxt = msg[cnt_nxt];
    end
    sym_nxt  = {u_nxt ^ s1 ^ s0, u_nxt ^ s0};
  end

  // Control FSM with registered symbol stream, code word, busy and done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      msg       <= '0;
      cnt       <= '0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
      code_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st) begin
            // First bit always starts from trellis state 00, so its
            // symbol is simply {u, u}.
            msg       <= msg_load;
            cnt       <= '0;
            s1        <= msg_load[0];
            s0        <= 1'b0;
            sym_out   <= {msg_load[0], msg_load[0]};
            sym_valid <= 1'b1;
            code_out  <= '0;
            busy      <= 1'b1;
            state     <= ENC;
          end
        end
        ENC: begin
          code_out[2*int'(cnt) +: 2] <= sym_out;
          if (cnt == LAST) begin
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt     <= cnt_nxt;
            sym_out <= sym_nxt;
            s0      <= s1;
            s1      <= u_nxt;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
